// File: rtl/delay_measure_ctrl.sv
// Launch/capture controller: toggles path_input once per trial, times the
// synchronized path_result response, and accumulates sum/min/max/last latency.
module delay_measure_ctrl #(
  parameter int CNT_W      = 32,
  parameter int LOG_TRIALS = 4,
  parameter int SETTLE     = 16,
  parameter int TIMEOUT    = 1024,
  parameter bit INVERT     = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       path_input,
  input  logic                       path_result,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [LOG_TRIALS-1:0]      trial_idx,
  output logic [CNT_W-1:0]           last_lat,
  output logic [CNT_W+LOG_TRIALS-1:0] lat_sum,
  output logic [CNT_W-1:0]           lat_min,
  output logic [CNT_W-1:0]           lat_max
);

  localparam int SUM_W = CNT_W + LOG_TRIALS;
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0]      SET_LAST   = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]      TMO        = CNT_W'(TIMEOUT);
  localparam logic [LOG_TRIALS-1:0] LAST_TRIAL = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LAUNCH, S_WAIT, S_RECORD, S_DONE
  } state_t;

  state_t           state;
  logic [SET_W-1:0] settleCnt;
  logic [CNT_W-1:0] cnt;
  logic             s1, s2;
  logic             match;

  // path_result is unrelated to clk, so it only enters through two flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= path_result;
      s2 <= s1;
    end
  end

  assign match = (s2 == (path_input ^ INVERT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      settleCnt  <= '0;
      cnt        <= '0;
      path_input <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      trial_idx  <= '0;
      last_lat   <= '0;
      lat_sum    <= '0;
      lat_min    <= '0;
      lat_max    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lat_sum   <= '0;
            lat_max   <= '0;
            lat_min   <= '1;
            trial_idx <= '0;
            timeout   <= 1'b0;
            settleCnt <= '0;
            busy      <= 1'b1;
            state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settleCnt == SET_LAST) state <= S_LAUNCH;
          else settleCnt <= settleCnt + SET_W'(1);
        end
        S_LAUNCH: begin
          path_input <= ~path_input;
          cnt        <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // a match on the TIMEOUT cycle still counts as a good trial
          if (match) begin
            last_lat <= cnt;
            state    <= S_RECORD;
          end else if (cnt == TMO) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_RECORD: begin
          lat_sum   <= lat_sum + SUM_W'(last_lat);
          if (last_lat < lat_min) lat_min <= last_lat;
          if (last_lat > lat_max) lat_max <= last_lat;
          trial_idx <= trial_idx + LOG_TRIALS'(1);
          settleCnt <= '0;
          if (trial_idx == LAST_TRIAL) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_SETTLE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_measure_ctrl.sv
// Bench for delay_measure_ctrl: three instances (default, inverting, short
// timeout) behind a behavioral delay-line model of the path under test.
module tb_delay_measure_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]        startV, pinV, resV, busyV, doneV, toV;
  logic [2:0][3:0]   idxV;
  logic [2:0][31:0]  lastV, minV, maxV;
  logic [2:0][35:0]  sumV;

  int riseD [3];
  int fallD [3];
  bit stuck [3];
  logic [2:0][7:0] pd;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  delay_measure_ctrl #(.CNT_W(32), .LOG_TRIALS(4), .SETTLE(16), .TIMEOUT(1024), .INVERT(1'b0)) dutA (
    .clk(clk), .rst(rst), .start(startV[0]), .path_input(pinV[0]), .path_result(resV[0]),
    .busy(busyV[0]), .done(doneV[0]), .timeout(toV[0]), .trial_idx(idxV[0]),
    .last_lat(lastV[0]), .lat_sum(sumV[0]), .lat_min(minV[0]), .lat_max(maxV[0]));

  delay_measure_ctrl #(.CNT_W(32), .LOG_TRIALS(4), .SETTLE(16), .TIMEOUT(1024), .INVERT(1'b1)) dutB (
    .clk(clk), .rst(rst), .start(startV[1]), .path_input(pinV[1]), .path_result(resV[1]),
    .busy(busyV[1]), .done(doneV[1]), .timeout(toV[1]), .trial_idx(idxV[1]),
    .last_lat(lastV[1]), .lat_sum(sumV[1]), .lat_min(minV[1]), .lat_max(maxV[1]));

  delay_measure_ctrl #(.CNT_W(32), .LOG_TRIALS(4), .SETTLE(2), .TIMEOUT(5), .INVERT(1'b0)) dutC (
    .clk(clk), .rst(rst), .start(startV[2]), .path_input(pinV[2]), .path_result(resV[2]),
    .busy(busyV[2]), .done(doneV[2]), .timeout(toV[2]), .trial_idx(idxV[2]),
    .last_lat(lastV[2]), .lat_sum(sumV[2]), .lat_min(minV[2]), .lat_max(maxV[2]));

  // path model: history of path_input, separate delays for rising/falling edges
  always_ff @(posedge clk)
    for (int i = 0; i < 3; i++) pd[i] <= {pd[i][6:0], pinV[i]};

  function automatic logic tap(logic [7:0] h, logic cur, int d);
    return (d == 0) ? cur : h[d-1];
  endfunction

  always_comb begin
    logic r;
    r    = 1'b0;
    resV = '0;
    for (int i = 0; i < 3; i++) begin
      if (riseD[i] <= fallD[i])
        r = tap(pd[i], pinV[i], riseD[i]) | tap(pd[i], pinV[i], fallD[i]);
      else
        r = tap(pd[i], pinV[i], riseD[i]) & tap(pd[i], pinV[i], fallD[i]);
      if (i == 1) r = ~r;
      resV[i] = stuck[i] ? 1'b0 : r;
    end
  end

  typedef struct {
    int     dut;
    int     rD;
    int     fD;
    bit     stk;
    bit     expTo;
    int     expIdx;
    longint expSum;
    longint expMin;
    longint expMax;
    longint expLast;
    int     expCyc;
    bit     expPin;
    int     extraStartAt;
  } vec_t;

  vec_t vecs [8];
  vec_t sb [$];

  task automatic chk(string nm, longint act, longint exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic runVec(int n, vec_t v);
    int   d;
    int   cyc;
    bit   seen;
    vec_t e;
    d = v.dut;
    riseD[d] = v.rD;
    fallD[d] = v.fD;
    stuck[d] = v.stk;
    sb.push_back(v);
    startV[d] = 1'b1;
    @(posedge clk); #1;
    startV[d] = 1'b0;
    cyc = 1;
    chk($sformatf("v%0d_busy_rise", n), busyV[d], 1);
    seen = 1'b0;
    while (!seen && cyc < v.expCyc + 50) begin
      if (doneV[d]) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
        startV[d] = (v.extraStartAt != 0 && cyc == v.extraStartAt);
      end
    end
    startV[d] = 1'b0;
    e = sb.pop_front();
    chk($sformatf("v%0d_done_seen", n), seen, 1);
    if (seen) begin
      chk($sformatf("v%0d_done_cycle", n), cyc, e.expCyc);
      chk($sformatf("v%0d_busy_at_done", n), busyV[d], 1);
      chk($sformatf("v%0d_timeout", n), toV[d], e.expTo);
      chk($sformatf("v%0d_trial_idx", n), idxV[d], e.expIdx);
      chk($sformatf("v%0d_lat_sum", n), sumV[d], e.expSum);
      chk($sformatf("v%0d_lat_min", n), minV[d], e.expMin);
      chk($sformatf("v%0d_lat_max", n), maxV[d], e.expMax);
      chk($sformatf("v%0d_last_lat", n), lastV[d], e.expLast);
      chk($sformatf("v%0d_path_input", n), pinV[d], e.expPin);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_one_cycle", n), doneV[d], 0);
      chk($sformatf("v%0d_busy_drop", n), busyV[d], 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cnt;
    bit  sawDone;
    bit  sawBusy;
    //          dut rD fD stk to idx sum  min           max last cyc   pin xs
    vecs[0] = '{0,  0, 0, 0,  0, 0,  32,  2,            2,  2,   337,  0,  0};
    vecs[1] = '{0,  3, 3, 0,  0, 0,  80,  5,            5,  5,   385,  0,  0};
    vecs[2] = '{0,  1, 4, 0,  0, 0,  72,  3,            6,  6,   377,  0,  0};
    vecs[3] = '{0,  0, 0, 1,  1, 0,  0,   'hFFFFFFFF,   0,  6,   1043, 1,  0};
    vecs[4] = '{1,  0, 0, 0,  0, 0,  32,  2,            2,  2,   337,  0,  0};
    vecs[5] = '{2,  3, 3, 0,  0, 0,  80,  5,            5,  5,   161,  0,  0};
    vecs[6] = '{2,  4, 4, 0,  1, 0,  0,   'hFFFFFFFF,   0,  5,   10,   1,  0};
    vecs[7] = '{0,  0, 0, 0,  0, 0,  32,  2,            2,  2,   337,  0,  50};

    for (int i = 0; i < 3; i++) begin
      riseD[i] = 0; fallD[i] = 0; stuck[i] = 1'b0;
    end
    startV = '0;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busyV[0], 0);
    chk("rst_done", doneV[0], 0);
    chk("rst_timeout", toV[0], 0);
    chk("rst_trial_idx", idxV[0], 0);
    chk("rst_last_lat", lastV[0], 0);
    chk("rst_lat_sum", sumV[0], 0);
    chk("rst_lat_min", minV[0], 0);
    chk("rst_lat_max", maxV[0], 0);
    chk("rst_path_input", pinV[0], 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      runVec(i, vecs[i]);
      repeat (5) @(posedge clk);
      #1;
    end

    // reset asserted in the middle of trial 5's WAIT
    riseD[0] = 0; fallD[0] = 0; stuck[0] = 1'b0;
    startV[0] = 1'b1;
    @(posedge clk); #1;
    startV[0] = 1'b0;
    cnt = 0;
    sawDone = 1'b0;
    while (idxV[0] != 4'd5 && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
      if (doneV[0]) sawDone = 1'b1;
    end
    chk("midrst_reached_trial5", idxV[0], 5);
    repeat (18) begin
      @(posedge clk); #1;
      if (doneV[0]) sawDone = 1'b1;
    end
    chk("midrst_busy_before", busyV[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busyV[0], 0);
    chk("midrst_trial_idx", idxV[0], 0);
    chk("midrst_last_lat", lastV[0], 0);
    chk("midrst_lat_sum", sumV[0], 0);
    chk("midrst_lat_min", minV[0], 0);
    chk("midrst_lat_max", maxV[0], 0);
    chk("midrst_path_input", pinV[0], 0);
    chk("midrst_timeout", toV[0], 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (doneV[0]) sawDone = 1'b1;
    end
    chk("midrst_no_done", sawDone, 0);

    // start coinciding with reset is dropped
    rst = 1'b1;
    startV[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    startV[0] = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_busy", busyV[0], 0);

    // clean run with a stray start pulse while busy
    runVec(7, vecs[7]);
    sawBusy = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busyV[0]) sawBusy = 1'b1;
    end
    chk("start_while_busy_ignored", sawBusy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
